// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and FSM state encodings.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_EMPTY   = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_MSB = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO for the UART transmitter; a push while full is
// dropped, and push and pop on the same edge keep the count unchanged.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, register file and the
// serialiser FSM, fed from a small TX FIFO.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        txd,
  output logic        irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       r_state;
  logic             r_txd;
  logic [7:0]       r_shift;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_divLatch;
  logic [DIV_W-1:0] r_bitCnt;
  logic [2:0]       r_bitIdx;
  logic             r_ovf;

  logic [1:0]       w_sel;
  logic             w_wr;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [7:0]       w_dout;
  logic             w_bitEnd;
  logic             w_unused;

  assign w_sel    = addr[3:2];
  assign w_wr     = ce && we;
  assign w_push   = w_wr && (w_sel == REG_TXDATA);
  assign w_bitEnd = (r_bitCnt == r_divLatch - DIV_W'(1));
  // Pop on entry from IDLE, or at the end of STOP to chain frames without a gap.
  assign w_pop    = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bitEnd));
  assign w_unused = ^{addr[31:4], addr[1:0], dataIn};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (dataIn[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= DIV_W'(CLK_DIV);
      r_ovf <= 1'b0;
    end else begin
      if (w_wr && (w_sel == REG_STATUS) && dataIn[ST_OVF]) r_ovf <= 1'b0;
      if (w_push && w_full) r_ovf <= 1'b1;
      if (w_wr && (w_sel == REG_DIV))
        r_div <= (dataIn[DIV_W-1:0] == '0) ? DIV_W'(1) : dataIn[DIV_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_txd      <= 1'b1;
      r_shift    <= '0;
      r_divLatch <= DIV_W'(CLK_DIV);
      r_bitCnt   <= '0;
      r_bitIdx   <= '0;
    end else begin
      if (w_pop) begin
        r_shift    <= w_dout;
        r_divLatch <= r_div;
        r_bitCnt   <= '0;
        r_txd      <= 1'b0;
        r_state    <= S_START;
      end else if (r_state != S_IDLE) begin
        if (!w_bitEnd) begin
          r_bitCnt <= r_bitCnt + DIV_W'(1);
        end else begin
          r_bitCnt <= '0;
          case (r_state)
            S_START: begin
              r_state  <= S_DATA;
              r_txd    <= r_shift[0];
              r_bitIdx <= '0;
            end
            S_DATA: begin
              if (r_bitIdx == 3'd7) begin
                r_state <= S_STOP;
                r_txd   <= 1'b1;
              end else begin
                r_shift  <= r_shift >> 1;
                r_txd    <= r_shift[1];
                r_bitIdx <= r_bitIdx + 3'd1;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    dataOut = '0;
    if (ce) begin
      case (w_sel)
        REG_STATUS: begin
          dataOut[ST_BUSY]                = (r_state != S_IDLE);
          dataOut[ST_FULL]                = w_full;
          dataOut[ST_EMPTY]               = w_empty;
          dataOut[ST_OVF]                 = r_ovf;
          dataOut[ST_CNT_MSB:ST_CNT_LSB]  = 5'(w_count);
        end
        REG_DIV: dataOut = 32'(r_div);
        default: dataOut = '0;
      endcase
    end
  end

  assign txd = r_txd;
  assign irq = w_empty && (r_state == S_IDLE);

endmodule
